// File: rtl/rej_uniform_sampler_ctrl.sv
// Kyber matrix-A rejection sampler: pairs squeeze bytes into LE 16-bit candidates, keeps those < 19q, writes them mod q.
// Latency: start -> squeeze_req next cycle; 3 cycles per byte pair (LOW, HIGH, EVAL) plus one REQ cycle per rate block.
// Backpressure: byte_ready only in LOW/HIGH; byte_valid low stalls indefinitely with the partial pair held.
module rej_uniform_sampler_ctrl #(
    parameter int KYBER_N          = 256,
    parameter int KYBER_Q          = 3329,
    parameter int COMPARE_CONSTANT = 63251,
    parameter int RATE_BYTES       = 168,
    parameter int ADDR_W           = 8,
    parameter int COEFF_W          = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               squeeze_req,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               coeff_we,
    output logic [ADDR_W-1:0]  coeff_addr,
    output logic [COEFF_W-1:0] coeff_data
);

    // Byte counter must reach RATE_BYTES; coefficient counter must reach KYBER_N.
    localparam int BCNT_W = $clog2(RATE_BYTES + 1);
    localparam int CCNT_W = $clog2(KYBER_N + 1);
    // One spare bit above the 16-bit candidate keeps every subtraction and compare unsigned-safe.
    localparam int VAL_W  = 17;

    localparam logic [VAL_W-1:0]  CMP_K  = VAL_W'(COMPARE_CONSTANT);
    localparam logic [VAL_W-1:0]  Q1_K   = VAL_W'(KYBER_Q);
    localparam logic [VAL_W-1:0]  Q2_K   = VAL_W'(2 * KYBER_Q);
    localparam logic [VAL_W-1:0]  Q4_K   = VAL_W'(4 * KYBER_Q);
    localparam logic [VAL_W-1:0]  Q8_K   = VAL_W'(8 * KYBER_Q);
    localparam logic [VAL_W-1:0]  Q16_K  = VAL_W'(16 * KYBER_Q);
    localparam logic [BCNT_W-1:0] RATE_K = BCNT_W'(RATE_BYTES);
    localparam logic [CCNT_W-1:0] N_K    = CCNT_W'(KYBER_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOW,
        S_HIGH,
        S_EVAL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         low_q, low_d;
    logic [7:0]         high_q, high_d;
    logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [CCNT_W-1:0]  coeff_cnt_q, coeff_cnt_d;

    logic [VAL_W-1:0]   cand;
    logic [VAL_W-1:0]   rem16, rem8, rem4, rem2;
    logic               accept;
    logic [COEFF_W-1:0] coeff_red;

    // State and datapath registers; reset aborts any run with no further writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            low_q       <= '0;
            high_q      <= '0;
            byte_cnt_q  <= '0;
            coeff_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            low_q       <= low_d;
            high_q      <= high_d;
            byte_cnt_q  <= byte_cnt_d;
            coeff_cnt_q <= coeff_cnt_d;
        end
    end

    // Candidate compare and exact mod-q by conditional subtraction of 16q, 8q, 4q, 2q, q.
    // An input below 19q leaves < 16q after the first step, then each step halves the bound down to < q.
    always_comb begin
        cand      = {1'b0, high_q, low_q};
        accept    = (cand < CMP_K);
        rem16     = (cand  >= Q16_K) ? (cand  - Q16_K) : cand;
        rem8      = (rem16 >= Q8_K)  ? (rem16 - Q8_K)  : rem16;
        rem4      = (rem8  >= Q4_K)  ? (rem8  - Q4_K)  : rem8;
        rem2      = (rem4  >= Q2_K)  ? (rem4  - Q2_K)  : rem4;
        coeff_red = (rem2  >= Q1_K)  ? COEFF_W'(rem2 - Q1_K) : COEFF_W'(rem2);
    end

    // Next-state and Moore-style outputs; RAM address/data are driven only while writing.
    always_comb begin
        state_d     = state_q;
        low_d       = low_q;
        high_d      = high_q;
        byte_cnt_d  = byte_cnt_q;
        coeff_cnt_d = coeff_cnt_q;
        busy        = 1'b0;
        done        = 1'b0;
        squeeze_req = 1'b0;
        byte_ready  = 1'b0;
        coeff_we    = 1'b0;
        coeff_addr  = '0;
        coeff_data  = '0;

        case (state_q)
            S_IDLE: begin
                byte_cnt_d  = '0;
                coeff_cnt_d = '0;
                if (start) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                busy        = 1'b1;
                squeeze_req = 1'b1;
                byte_cnt_d  = '0;
                state_d     = S_LOW;
            end

            S_LOW: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    low_d      = byte_data;
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    state_d    = S_HIGH;
                end
            end

            S_HIGH: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    high_d     = byte_data;
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    state_d    = S_EVAL;
                end
            end

            S_EVAL: begin
                busy = 1'b1;
                if (accept) begin
                    coeff_we    = 1'b1;
                    coeff_addr  = coeff_cnt_q[ADDR_W-1:0];
                    coeff_data  = coeff_red;
                    coeff_cnt_d = coeff_cnt_q + CCNT_W'(1);
                end
                // Completion beats block exhaustion: a finished polynomial never requests more bytes.
                // RATE_BYTES is even, so the block can only run out here, never between LOW and HIGH.
                if (coeff_cnt_d == N_K) begin
                    state_d = S_DONE;
                end else if (byte_cnt_q == RATE_K) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_LOW;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/rej_uniform_sampler_ctrl.md
# rej_uniform_sampler_ctrl

Sequencing controller for Kyber matrix-A rejection sampling. Consumes the SHAKE128 squeeze byte stream one byte at a time and pairs bytes into little-endian 16-bit candidates. Each candidate is compared against 19·q; accepted candidates are reduced mod q and written to polynomial RAM until KYBER_N coefficients exist. It requests a new squeeze block from the Keccak core whenever a rate block is exhausted, and sits between the Keccak squeeze output and the polynomial coefficient RAM.

## Interface
- KYBER_N, 256: coefficients per polynomial.
- KYBER_Q, 3329: modulus.
- COMPARE_CONSTANT, 63251: rejection bound (19·KYBER_Q).
- RATE_BYTES, 168: SHAKE128 rate; must be even.
- ADDR_W, 8: coefficient address width (log2 KYBER_N).
- COEFF_W, 12: reduced coefficient width.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: begin sampling one polynomial; sampled only in IDLE.
- busy, out, 1: high from the cycle after start until DONE.
- done, out, 1: one-cycle pulse when coefficient KYBER_N-1 has been written.
- squeeze_req, out, 1: one-cycle pulse requesting the next RATE_BYTES block.
- byte_valid, in, 1: upstream byte available.
- byte_data, in, 8: squeeze byte, in stream order.
- byte_ready, out, 1: byte consumed on a cycle where byte_valid and byte_ready are both high.
- coeff_we, out, 1: coefficient RAM write enable.
- coeff_addr, out, ADDR_W: write address, equal to the accepted-coefficient index.
- coeff_data, out, COEFF_W: reduced coefficient.

## Operation
- FSM states: IDLE, REQ, LOW, HIGH, EVAL, DONE.
- IDLE: on start go to REQ. Clear coeff_cnt and byte_cnt.
- REQ: assert squeeze_req for one cycle, clear byte_cnt, then go to LOW.
- LOW: byte_ready=1. On handshake, latch the low byte, increment byte_cnt, and go to HIGH.
- HIGH: byte_ready=1. On handshake, latch the high byte, increment byte_cnt, and go to EVAL.
- EVAL: byte_ready=0. Form val = {high, low}, with the first byte as the LSB.
  - If val < COMPARE_CONSTANT (strict), the candidate is accepted: coeff_we=1, coeff_addr=coeff_cnt, coeff_data = val mod KYBER_Q (exact, 0..3328), then coeff_cnt++.
  - Otherwise it is rejected: no write, and coeff_cnt is unchanged.
- EVAL exit priority:
  1. coeff_cnt reaches KYBER_N after this write: go to DONE.
  2. byte_cnt == RATE_BYTES: go to REQ.
  3. Otherwise go to LOW.
- DONE: pulse done for one cycle and go to IDLE. Unconsumed bytes of the current block are abandoned; the upstream core flushes them.
- Reduction: exact mod for 0 ≤ val < 63251, computed combinationally within EVAL. Conditional subtraction of 16q, 8q, 4q, 2q, q is acceptable. No Barrett approximation error is permitted.
- Because RATE_BYTES is even, a pair never straddles two blocks.
- start while busy is ignored. byte_valid outside LOW/HIGH is ignored.

## Timing
- Reset values: busy=0, done=0, squeeze_req=0, byte_ready=0, coeff_we=0, coeff_addr=0, coeff_data=0. State is IDLE; counters are 0.
- Reset asserted mid-operation aborts immediately and produces no further writes. The next start begins from address 0.
- start at cycle t: busy=1 and squeeze_req=1 at t+1; byte_ready=1 from t+2.
- Per pair, with byte_valid held high: LOW, HIGH, EVAL, i.e. 3 cycles. coeff_we appears in the EVAL cycle, one cycle after the high-byte handshake.
- Block boundary: after the 84th pair's EVAL, one REQ cycle (squeeze_req pulse) precedes the next LOW.
- done asserts the cycle after the final coeff_we; busy drops in the same cycle as done.
- byte_valid low stalls in LOW/HIGH indefinitely with no timeout. Partial pair state is held.

## Test plan
- Bytes 0x01, 0x02 → val 0x0201=513; coeff_we with coeff_addr=0, coeff_data=513. This verifies little-endian ordering.
- Bytes 0x12, 0xF7 → val 63250, accepted, coeff_data=3328. Bytes 0x13, 0xF7 → val 63251, rejected, no write and coeff_cnt unchanged.
- Stream of 168 bytes all 0xFF followed by bytes 0x00, 0x00:
  - 84 rejections with no writes.
  - Exactly two squeeze_req pulses: one at start, one after byte 168.
  - The next pair writes coeff 0 at addr 0.
- Full run of random bytes checked against a reference model:
  - 256 writes with addresses 0..255 in order and every coeff_data < 3329.
  - done is a single pulse one cycle after the addr-255 write.
  - byte_ready is low thereafter.
- Assert rst during HIGH after 10 writes → all outputs are at reset values in the same cycle. A subsequent start writes beginning at addr 0 and issues a fresh squeeze_req.
- byte_valid toggled randomly and start pulsed while busy → identical coefficient sequence to the unstalled run; the stray start has no effect.
